// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main control FSM for a multi-cycle RV32I datapath.
//
// Sequences fetch, decode, execute, memory access and writeback, driving the
// datapath write enables, mux selects, alu_op and imm_src. All control
// outputs are decoded from the current state; mem_ready and zero only
// qualify write enables and state transitions.
//
// Memory handshake (valid/ready style): mem_req is the request and is held,
// together with mem_write and adr_src, until mem_ready is sampled high on a
// rising edge. mem_ready is ignored while mem_req is low. mem_ready high in
// the first request cycle completes the access with zero wait states.
//
// Parameters:
//   MAX_WAIT    memory wait-cycle limit per access, 0 = unlimited
//   PERF_CNT_W  width of the performance counters
//
// Optional feature macro: PERF_CNT_EN builds the cycle and retired-instruction
// counters; without it instret_cnt and cycle_cnt are constant 0.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   opcode                instruction bits [6:0] from the instruction register
//   zero                  ALU zero flag (branch decision)
//   mem_ready             memory completes the current access
//   mem_req, mem_write    memory request / write qualifier
//   adr_src               memory address select: 0 PC, 1 ALUOut
//   ir_write, pc_write    instruction register / PC load enables
//   reg_write             register-file write enable
//   alu_src_a, alu_src_b  ALU operand selects
//   result_src            result mux select
//   imm_src               immediate format: 00 I, 01 S, 10 B, 11 J
//   alu_op                00 add, 01 sub, 10 funct-decoded
//   illegal, bus_err      sticky traps (illegal opcode, memory timeout)
//   state_dbg             current state encoding
//   instret_cnt, cycle_cnt performance counters
module multicycle_ctrl #(
    parameter int MAX_WAIT   = 0,
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_write,
    output logic                  adr_src,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [1:0]            imm_src,
    output logic [1:0]            alu_op,
    output logic                  illegal,
    output logic                  bus_err,
    output logic [3:0]            state_dbg,
    output logic [PERF_CNT_W-1:0] instret_cnt,
    output logic [PERF_CNT_W-1:0] cycle_cnt
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_JALRT    = 4'd11,
        S_JALRL    = 4'd12,
        S_TRAP     = 4'd13
    } state_e;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    state_e            state_q, state_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        illegal_q <= illegal_d;
        bus_err_q <= bus_err_d;
        wait_q    <= wait_d;
    end

    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        bus_err_d  = bus_err_q;
        wait_d     = wait_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        imm_src    = 2'b00;
        alu_op     = 2'b00;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        state_dbg  = 4'd0;

        if (reset) begin
            // Reset forces every output low, which also aborts any pending access.
            state_d   = S_FETCH;
            illegal_d = 1'b0;
            bus_err_d = 1'b0;
            wait_d    = '0;
        end else begin
            state_dbg = state_q;
            illegal   = illegal_q;
            bus_err   = bus_err_q;

            case (state_q)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end
                end
                S_DECODE: begin
                    // Precompute the branch/jump target into ALUOut.
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    if (opcode == OP_BEQ)      imm_src = 2'b10;
                    else if (opcode == OP_JAL) imm_src = 2'b11;
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = S_MEMADR;
                        OP_R:              state_d = S_EXECR;
                        OP_I:              state_d = S_EXECI;
                        OP_BEQ:            state_d = S_BEQ;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALRT;
                        default: begin
                            state_d   = S_TRAP;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    if (opcode == OP_STORE) begin
                        imm_src = 2'b01;
                        state_d = S_MEMWRITE;
                    end else begin
                        state_d = S_MEMREAD;
                    end
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    if (mem_ready) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    adr_src   = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
                S_EXECR: begin
                    alu_src_a = 2'b10;
                    alu_op    = 2'b10;
                    state_d   = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                    state_d   = S_ALUWB;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BEQ: begin
                    // ALUOut still holds the target computed in DECODE.
                    alu_src_a = 2'b10;
                    alu_op    = 2'b01;
                    pc_write  = zero;
                    state_d   = S_FETCH;
                end
                S_JAL: begin
                    // PC <- target from DECODE while the ALU forms OldPC+4 for rd.
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                    state_d   = S_ALUWB;
                end
                S_JALRT: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    state_d   = S_JALRL;
                end
                S_JALRL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                    state_d   = S_ALUWB;
                end
                S_TRAP: begin
                    state_d = S_TRAP;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase

            // Wait-state counter: counts stalled request cycles; the cycle that
            // would reach MAX_WAIT drops the access and traps instead.
            if (mem_req) begin
                if (mem_ready) begin
                    wait_d = '0;
                end else if (MAX_WAIT > 0) begin
                    if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
                        state_d   = S_TRAP;
                        bus_err_d = 1'b1;
                        wait_d    = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
            end
        end
    end

`ifdef PERF_CNT_EN
    logic [PERF_CNT_W-1:0] instret_q, cycle_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            instret_q <= '0;
            cycle_q   <= '0;
        end else begin
            cycle_q <= cycle_q + 1'b1;
            // An instruction retires when control returns to FETCH.
            if (state_q != S_FETCH && state_q != S_TRAP && state_d == S_FETCH) begin
                instret_q <= instret_q + 1'b1;
            end
        end
    end

    assign instret_cnt = reset ? '0 : instret_q;
    assign cycle_cnt   = reset ? '0 : cycle_q;
`else
    assign instret_cnt = '0;
    assign cycle_cnt   = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl (MAX_WAIT = 4). Each driven cycle pushes its
// hand-written expected output vector into exp_q; a negedge monitor pops and
// compares it against the DUT outputs.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BAD   = 7'b0000000;

    localparam logic [3:0] ST_FETCH    = 4'd0;
    localparam logic [3:0] ST_DECODE   = 4'd1;
    localparam logic [3:0] ST_MEMADR   = 4'd2;
    localparam logic [3:0] ST_MEMREAD  = 4'd3;
    localparam logic [3:0] ST_MEMWB    = 4'd4;
    localparam logic [3:0] ST_MEMWRITE = 4'd5;
    localparam logic [3:0] ST_EXECR    = 4'd6;
    localparam logic [3:0] ST_EXECI    = 4'd7;
    localparam logic [3:0] ST_ALUWB    = 4'd8;
    localparam logic [3:0] ST_BEQ      = 4'd9;
    localparam logic [3:0] ST_JAL      = 4'd10;
    localparam logic [3:0] ST_JALRT    = 4'd11;
    localparam logic [3:0] ST_JALRL    = 4'd12;
    localparam logic [3:0] ST_TRAP     = 4'd13;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  opcode = 7'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src, imm_src, alu_op;
    logic        illegal, bus_err;
    logic [3:0]  state_dbg;
    logic [31:0] instret_cnt, cycle_cnt;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MAX_WAIT(4), .PERF_CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .alu_op     (alu_op),
        .illegal    (illegal),
        .bus_err    (bus_err),
        .state_dbg  (state_dbg),
        .instret_cnt(instret_cnt),
        .cycle_cnt  (cycle_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [37:0] exp_q[$];
    string       name_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    // Expected-counter model state.
    int          cyc_m = 0;
    int          ins_m = 0;
    logic [3:0]  prev_st = ST_FETCH;
    logic        prev_rst = 1'b1;

    // State-fixed outputs: {mem_req, mem_write, adr_src, a, b, result_src, alu_op}.
    function automatic logic [10:0] state_base(input logic [3:0] st);
        case (st)
            ST_FETCH:    return 11'b100_00_10_10_00;
            ST_DECODE:   return 11'b000_01_01_00_00;
            ST_MEMADR:   return 11'b000_10_01_00_00;
            ST_MEMREAD:  return 11'b101_00_00_00_00;
            ST_MEMWB:    return 11'b000_00_00_01_00;
            ST_MEMWRITE: return 11'b111_00_00_00_00;
            ST_EXECR:    return 11'b000_10_00_00_10;
            ST_EXECI:    return 11'b000_10_01_00_10;
            ST_BEQ:      return 11'b000_10_00_00_01;
            ST_JAL:      return 11'b000_01_10_00_00;
            ST_JALRT:    return 11'b000_10_01_00_00;
            ST_JALRL:    return 11'b000_01_10_00_00;
            default:     return 11'b000_00_00_00_00;
        endcase
    endfunction

    // ---------------- driver ----------------
    // wen = {ir_write, pc_write, reg_write}
    task automatic step(input string nm, input logic rst, input logic [6:0] opc,
                        input logic z, input logic rdy, input logic [3:0] st,
                        input logic [2:0] wen, input logic [1:0] imm,
                        input logic ill, input logic berr);
        logic [10:0] b;
        logic [21:0] v;
        logic [7:0]  ins_e, cyc_e;
        @(posedge clk);
        #1;
        reset     = rst;
        opcode    = opc;
        zero      = z;
        mem_ready = rdy;
        if (rst) begin
            v     = '0;
            ins_e = 8'd0;
            cyc_e = 8'd0;
            cyc_m = 0;
            ins_m = 0;
            prev_st  = ST_FETCH;
            prev_rst = 1'b1;
        end else begin
            b = state_base(st);
            v = {st, b[10:8], wen, b[7:2], imm, b[1:0], ill, berr};
            if (st == ST_FETCH && prev_st != ST_FETCH && prev_st != ST_TRAP && !prev_rst)
                ins_m++;
`ifdef PERF_CNT_EN
            ins_e = 8'(ins_m);
            cyc_e = 8'(cyc_m);
`else
            ins_e = 8'd0;
            cyc_e = 8'd0;
`endif
            cyc_m++;
            prev_st  = st;
            prev_rst = 1'b0;
        end
        exp_q.push_back({v, ins_e, cyc_e});
        name_q.push_back(nm);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [37:0] got, exp;
        string       nm;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {state_dbg, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, result_src, imm_src, alu_op, illegal, bus_err,
                   instret_cnt[7:0], cycle_cnt[7:0]};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", nm, got, exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        step("reset0", 1, OP_R, 0, 1, ST_FETCH, 3'b000, 2'b00, 0, 0);
        step("reset1", 1, OP_R, 0, 1, ST_FETCH, 3'b000, 2'b00, 0, 0);

        // R-type, zero wait
        step("r_fetch",  0, OP_R, 0, 1, ST_FETCH,  3'b110, 2'b00, 0, 0);
        step("r_decode", 0, OP_R, 0, 1, ST_DECODE, 3'b000, 2'b00, 0, 0);
        step("r_exec",   0, OP_R, 0, 1, ST_EXECR,  3'b000, 2'b00, 0, 0);
        step("r_wb",     0, OP_R, 0, 1, ST_ALUWB,  3'b001, 2'b00, 0, 0);

        // I-type
        step("i_fetch",  0, OP_I, 0, 1, ST_FETCH,  3'b110, 2'b00, 0, 0);
        step("i_decode", 0, OP_I, 0, 1, ST_DECODE, 3'b000, 2'b00, 0, 0);
        step("i_exec",   0, OP_I, 0, 1, ST_EXECI,  3'b000, 2'b00, 0, 0);
        step("i_wb",     0, OP_I, 0, 1, ST_ALUWB,  3'b001, 2'b00, 0, 0);

        // Load with three wait states in MEMREAD
        step("ld_fetch",  0, OP_LOAD, 0, 1, ST_FETCH,   3'b110, 2'b00, 0, 0);
        step("ld_decode", 0, OP_LOAD, 0, 1, ST_DECODE,  3'b000, 2'b00, 0, 0);
        step("ld_adr",    0, OP_LOAD, 0, 1, ST_MEMADR,  3'b000, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++)
            step("ld_wait", 0, OP_LOAD, 0, 0, ST_MEMREAD, 3'b000, 2'b00, 0, 0);
        step("ld_done",   0, OP_LOAD, 0, 1, ST_MEMREAD, 3'b000, 2'b00, 0, 0);
        step("ld_wb",     0, OP_LOAD, 0, 1, ST_MEMWB,   3'b001, 2'b00, 0, 0);

        // BEQ taken then not taken
        step("beq1_fetch",  0, OP_BEQ, 1, 1, ST_FETCH,  3'b110, 2'b00, 0, 0);
        step("beq1_decode", 0, OP_BEQ, 1, 1, ST_DECODE, 3'b000, 2'b10, 0, 0);
        step("beq1_taken",  0, OP_BEQ, 1, 1, ST_BEQ,    3'b010, 2'b00, 0, 0);
        step("beq0_fetch",  0, OP_BEQ, 0, 1, ST_FETCH,  3'b110, 2'b00, 0, 0);
        step("beq0_decode", 0, OP_BEQ, 0, 1, ST_DECODE, 3'b000, 2'b10, 0, 0);
        step("beq0_nottkn", 0, OP_BEQ, 0, 1, ST_BEQ,    3'b000, 2'b00, 0, 0);

        // JAL
        step("jal_fetch",  0, OP_JAL, 0, 1, ST_FETCH,  3'b110, 2'b00, 0, 0);
        step("jal_decode", 0, OP_JAL, 0, 1, ST_DECODE, 3'b000, 2'b11, 0, 0);
        step("jal_jump",   0, OP_JAL, 0, 1, ST_JAL,    3'b010, 2'b00, 0, 0);
        step("jal_wb",     0, OP_JAL, 0, 1, ST_ALUWB,  3'b001, 2'b00, 0, 0);

        // JALR
        step("jalr_fetch",  0, OP_JALR, 0, 1, ST_FETCH,  3'b110, 2'b00, 0, 0);
        step("jalr_decode", 0, OP_JALR, 0, 1, ST_DECODE, 3'b000, 2'b00, 0, 0);
        step("jalr_tgt",    0, OP_JALR, 0, 1, ST_JALRT,  3'b000, 2'b00, 0, 0);
        step("jalr_link",   0, OP_JALR, 0, 1, ST_JALRL,  3'b010, 2'b00, 0, 0);
        step("jalr_wb",     0, OP_JALR, 0, 1, ST_ALUWB,  3'b001, 2'b00, 0, 0);

        // Store, zero wait
        step("st_fetch",  0, OP_STORE, 0, 1, ST_FETCH,    3'b110, 2'b00, 0, 0);
        step("st_decode", 0, OP_STORE, 0, 1, ST_DECODE,   3'b000, 2'b00, 0, 0);
        step("st_adr",    0, OP_STORE, 0, 1, ST_MEMADR,   3'b000, 2'b01, 0, 0);
        step("st_write",  0, OP_STORE, 0, 1, ST_MEMWRITE, 3'b000, 2'b00, 0, 0);

        // Store aborted by reset while waiting in MEMWRITE
        step("sta_fetch",  0, OP_STORE, 0, 1, ST_FETCH,    3'b110, 2'b00, 0, 0);
        step("sta_decode", 0, OP_STORE, 0, 1, ST_DECODE,   3'b000, 2'b00, 0, 0);
        step("sta_adr",    0, OP_STORE, 0, 1, ST_MEMADR,   3'b000, 2'b01, 0, 0);
        step("sta_wait",   0, OP_STORE, 0, 0, ST_MEMWRITE, 3'b000, 2'b00, 0, 0);
        step("sta_reset",  1, OP_STORE, 0, 0, ST_FETCH,    3'b000, 2'b00, 0, 0);

        // Illegal opcode -> TRAP, held for 10 cycles, then reset recovers
        step("ill_fetch",  0, OP_BAD, 0, 1, ST_FETCH,  3'b110, 2'b00, 0, 0);
        step("ill_decode", 0, OP_BAD, 0, 1, ST_DECODE, 3'b000, 2'b00, 0, 0);
        for (int i = 0; i < 10; i++)
            step("ill_trap", 0, OP_BAD, 1, 1, ST_TRAP, 3'b000, 2'b00, 1, 0);
        step("ill_reset",  1, OP_BAD, 0, 1, ST_FETCH, 3'b000, 2'b00, 0, 0);

        // Memory stuck in FETCH -> bus_err trap after 4 wait cycles
        for (int i = 0; i < 4; i++)
            step("to_wait", 0, OP_R, 0, 0, ST_FETCH, 3'b000, 2'b00, 0, 0);
        for (int i = 0; i < 3; i++)
            step("to_trap", 0, OP_R, 0, 1, ST_TRAP, 3'b000, 2'b00, 0, 1);
        step("to_reset",   1, OP_R, 0, 1, ST_FETCH,  3'b000, 2'b00, 0, 0);
        step("rec_fetch",  0, OP_R, 0, 1, ST_FETCH,  3'b110, 2'b00, 0, 0);
        step("rec_decode", 0, OP_R, 0, 1, ST_DECODE, 3'b000, 2'b00, 0, 0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback over several cycles.
- Drives register and PC write enables, mux selects, alu_op and imm_src. imm_src goes to the immediate generator: 00 I, 01 S, 10 B, 11 J.
- Handles the unified instruction/data memory handshake and traps illegal opcodes and memory timeouts.

Parameters:
- MAX_WAIT, default 0: memory wait-cycle limit per access; 0 = unlimited.
- PERF_CNT_W, default 32: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  7  instruction bits [6:0], from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access.
- mem_req  out  1  memory access request.
- mem_write  out  1  write access (valid only with mem_req).
- adr_src  out  1  memory address select: 0 PC, 1 ALUOut.
- ir_write  out  1  latch instruction and OldPC.
- pc_write  out  1  PC load enable.
- reg_write  out  1  register-file write.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1.
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result.
- imm_src  out  2  immediate format to the immediate generator.
- alu_op  out  2  00 add, 01 sub, 10 funct-decoded.
- illegal  out  1  sticky illegal-opcode trap.
- bus_err  out  1  sticky memory-timeout trap.
- state_dbg  out  4  current state encoding.
- instret_cnt  out  PERF_CNT_W  retired instructions.
- cycle_cnt  out  PERF_CNT_W  cycles since reset.

Behaviour:
- Outputs are decoded from the current state; mem_ready only qualifies the write enables. Unlisted outputs are 0 in every state.
- While reset is high: next state is FETCH, all outputs are 0, and illegal, bus_err and the wait counter clear. Reset during any state, including a pending memory access, aborts it; mem_req drops in the reset cycle.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10.
  - On mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay in FETCH with no writes.
- DECODE:
  - Outputs: a=01, b=01, alu_op=00; imm_src = 10 for opcode 1100011, 11 for 1101111, else 00.
  - Next state by opcode: 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BEQ; 1101111 -> JAL; 1100111 -> JALRT; any other -> TRAP with illegal=1.
- MEMADR: a=10, b=01, alu_op=00, imm_src=01 for stores, else 00. Go to MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_req=1, adr_src=1. Wait for mem_ready, then MEMWB.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Wait for mem_ready, then FETCH.
- EXECR: a=10, b=00, alu_op=10, then ALUWB.
- EXECI: a=10, b=01, imm_src=00, alu_op=10, then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00; pc_write=zero. Then FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1, then ALUWB. PC takes the target computed in DECODE; rd receives OldPC+4.
- JALRT: a=10, b=01, imm_src=00, alu_op=00, then JALRL.
- JALRL: a=01, b=10, result_src=00, pc_write=1, then ALUWB. The datapath clears target bit 0.
- TRAP: all enables 0; remain in TRAP until reset.
- Memory handshake:
  - mem_req, mem_write and the address selects stay stable until mem_ready is sampled high on a rising edge.
  - mem_ready is ignored while mem_req=0.
  - mem_ready high in the first request cycle gives zero wait states.
- Timeout: when MAX_WAIT>0, a wait counter increments on each cycle with mem_req=1 and mem_ready=0 and clears on completion. Reaching MAX_WAIT sends the FSM to TRAP with bus_err=1; the access is dropped and no write enable fires.
- Cycle counts at zero wait: R/I-type and JAL 4 cycles, load 5, store 4, BEQ 3, JALR 5.

Optional Feature:
- Macro: PERF_CNT_EN.
- Defined:
  - cycle_cnt increments every cycle after reset deasserts.
  - instret_cnt increments on every transition into FETCH from a non-FETCH state, excluding reset and TRAP.
  - Both counters wrap modulo 2^PERF_CNT_W and clear on reset.
- Undefined: both ports are constant 0 and the counter logic is not built.

Test Plan:
- Reset, then opcode 0110011 with mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB, FETCH; reg_write=1 only in ALUWB; instret_cnt=1.
- Load 0000011 with mem_ready held low 3 cycles in MEMREAD -> mem_req and adr_src=1 stable for 4 cycles; MEMWB follows; reg_write with result_src=01.
- BEQ with zero=1, then zero=0 -> pc_write=1 in BEQ only in the first case; imm_src=10 in DECODE.
- JAL 1101111 -> imm_src=11 in DECODE; pc_write in FETCH and JAL; rd written in ALUWB. JALR 1100111 -> JALRT/JALRL path with imm_src=00.
- Opcode 0000000 -> TRAP, illegal=1, all enables 0 for 10 cycles; reset returns to FETCH with illegal=0.
- MAX_WAIT=4, mem_ready stuck low in FETCH -> TRAP after 4 waits, bus_err=1. Reset asserted mid-MEMWRITE -> mem_req=0 in the reset cycle; FETCH follows.
